// File: rtl/load_counter_sched.sv
// load_counter_sched: round-robin scheduler that shares one load_counter
// among NUM_REQ requesters. Each job does three things in order: it loads the
// counter with the winner's start value, lets the counter run for the
// winner's run length, and then returns the final count with a done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; arbitrate and latch the winner
//   LOAD   | grant pulse, counter load strobe, run length armed
//   RUN    | counter free-runs; capture count when remaining hits 1
//   DONE   | done pulse to the owner, result valid
module load_counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 10,
    parameter int LEN_W   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      busy,
    output logic                      cnt_load_en,
    output logic [DATA_W-1:0]         cnt_data_in,
    input  logic [DATA_W-1:0]         cnt_count_out
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    win_idx;
    logic                win_found;
    logic [DATA_W-1:0]   sel_data;
    logic [LEN_W-1:0]    sel_len;
    logic [DATA_W-1:0]   data_lat;
    logic [LEN_W-1:0]    len_lat;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   result_q;
    logic [NUM_REQ-1:0]  owner_oh;

    // Round-robin pick: the smallest rotation distance k from the pointer wins,
    // so the loop walks k downwards and the last hit is the closest requester.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
                    win_idx   = PTR_W'(i);
                    win_found = 1'b1;
                end
            end
        end
    end

    // Mux the winner's start value and run length out of the packed buses.
    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore-decoded strobes.
    always_comb begin
        state_nxt   = state;
        grant       = '0;
        done        = '0;
        cnt_load_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt   = S_RUN;
                grant       = owner_oh;
                cnt_load_en = 1'b1;
            end
            S_RUN: begin
                if (remaining == LEN_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                done      = owner_oh;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job datapath: latch winner, arm the run length, advance pointer, capture count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            owner     <= '0;
            data_lat  <= '0;
            len_lat   <= '0;
            remaining <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        owner    <= win_idx;
                        data_lat <= sel_data;
                        len_lat  <= sel_len;
                    end
                end
                S_LOAD: begin
                    // A zero run length is treated as one so every job returns a count.
                    remaining <= (len_lat == '0) ? LEN_W'(1) : len_lat;
                    ptr       <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                S_RUN: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) result_q <= cnt_count_out;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign result      = result_q;
    assign cnt_data_in = data_lat;

endmodule

// File: tb/tb_load_counter_sched.sv
// Testbench for load_counter_sched: a behavioural counter drives cnt_count_out,
// a job-level reference model predicts each grant and done, and a monitor
// compares what the DUT presents against the predicted queue.
module tb_load_counter_sched;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 10;
    localparam int LEN_W   = 6;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        grant, done;
    logic [DATA_W-1:0]         result, cnt_data_in, cnt_count_out;
    logic                      busy, cnt_load_en;

    logic [NUM_REQ-1:0] rq = '0;
    logic [DATA_W-1:0]  rd [NUM_REQ];
    logic [LEN_W-1:0]   rl [NUM_REQ];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    load_counter_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .cnt_load_en(cnt_load_en), .cnt_data_in(cnt_data_in), .cnt_count_out(cnt_count_out)
    );

    always_comb begin
        req = rq;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = rd[i];
            req_len[i*LEN_W +: LEN_W]    = rl[i];
        end
    end

    // Behavioural load_counter: load on load_en, otherwise increment with wrap.
    logic [DATA_W-1:0] cnt_q = '0;
    always @(posedge clk) begin
        if (cnt_load_en) cnt_q <= cnt_data_in;
        else             cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_count_out = cnt_q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Job-level reference model. Cycle numbers: a request sampled at edge e
    // shows its grant in cycle e+1 and its done in cycle e+len+2; the block can
    // accept again at edge e+len+3.
    typedef struct {
        int                owner;
        int                gcyc;
        int                dcyc;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] res;
    } job_t;

    job_t gq[$];
    job_t dq[$];
    int   m_ptr = 0;
    int   next_free = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ptr = 0;
            next_free = cyc + 1;
            gq.delete();
            dq.delete();
        end else if (cyc >= next_free && rq != '0) begin
            job_t j;
            int w;
            int l;
            logic [1:0] idx;
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = 2'((m_ptr + k) % NUM_REQ);
                if (w < 0 && rq[idx]) w = int'(idx);
            end
            idx = 2'(w);
            l = int'(rl[idx]);
            if (l == 0) l = 1;
            j.owner = w;
            j.gcyc  = cyc + 1;
            j.dcyc  = cyc + l + 2;
            j.data  = rd[idx];
            j.res   = rd[idx] + DATA_W'(l - 1);
            gq.push_back(j);
            dq.push_back(j);
            next_free = cyc + l + 3;
            m_ptr = (w + 1) % NUM_REQ;
        end
        cyc = cyc + 1;
    end

    int glog[$];
    int glog_cyc[$];
    int dlog_cyc[$];
    int dlog_res[$];

    // Monitor: compare each grant/done pulse against the predicted queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (grant != '0) begin
                int gi;
                gi = -1;
                for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gi = i;
                glog.push_back(gi);
                glog_cyc.push_back(cyc);
                if (gq.size() == 0) begin
                    chk("grant_unexpected", int'(grant), 0);
                end else begin
                    job_t j;
                    j = gq.pop_front();
                    chk("grant_onehot", int'(grant), 1 << j.owner);
                    chk("grant_cycle", cyc, j.gcyc);
                    chk("grant_load_en", int'(cnt_load_en), 1);
                    chk("grant_data_in", int'(cnt_data_in), int'(j.data));
                end
            end
            if (done != '0) begin
                dlog_cyc.push_back(cyc);
                dlog_res.push_back(int'(result));
                if (dq.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    job_t j;
                    j = dq.pop_front();
                    chk("done_onehot", int'(done), 1 << j.owner);
                    chk("done_cycle", cyc, j.dcyc);
                    chk("done_result", int'(result), int'(j.res));
                end
            end
            while (gq.size() > 0 && cyc > gq[0].gcyc) begin
                chk("grant_missing", 0, 1 << gq[0].owner);
                void'(gq.pop_front());
            end
            while (dq.size() > 0 && cyc > dq[0].dcyc) begin
                chk("done_missing", 0, 1 << dq[0].owner);
                void'(dq.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (glog.size() < n && t < 400) begin step(); t++; end
        if (glog.size() < n) chk("wait_grants_timeout", glog.size(), n);
    endtask

    task automatic wait_dones(input int n);
        int t;
        t = 0;
        while (dlog_cyc.size() < n && t < 400) begin step(); t++; end
        if (dlog_cyc.size() < n) chk("wait_done_timeout", dlog_cyc.size(), n);
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((gq.size() > 0 || dq.size() > 0) && t < 400) begin step(); t++; end
        if (gq.size() > 0 || dq.size() > 0) chk("quiet_timeout", gq.size() + dq.size(), 0);
        step();
        step();
    endtask

    task automatic clear_logs();
        glog.delete();
        glog_cyc.delete();
        dlog_cyc.delete();
        dlog_res.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_load_en"}, int'(cnt_load_en), 0);
        chk({tag, "_data_in"}, int'(cnt_data_in), 0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < NUM_REQ; i++) begin rd[i] = '0; rl[i] = '0; end
        rq = '0;
        reset = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // All four requesting, len 2: strict rotation, 5 cycles apart.
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) begin
            rd[i] = DATA_W'($urandom);
            rl[i] = LEN_W'(2);
        end
        rq = 4'b1111;
        wait_grants(5);
        rq = '0;
        if (glog.size() >= 5) begin
            chk("rr_order0", glog[0], 0);
            chk("rr_order1", glog[1], 1);
            chk("rr_order2", glog[2], 2);
            chk("rr_order3", glog[3], 3);
            chk("rr_order4", glog[4], 0);
            for (int i = 1; i < 5; i++) chk("rr_period", glog_cyc[i] - glog_cyc[i-1], 5);
        end
        wait_quiet();

        // Single requester 2, data 0x100, len 5.
        clear_logs();
        rd[2] = 10'h100;
        rl[2] = 6'd5;
        t0 = cyc;
        rq = 4'b0100;
        wait_grants(1);
        rq = '0;
        wait_dones(1);
        if (dlog_cyc.size() >= 1) begin
            chk("t1_grant", glog[0], 2);
            chk("t1_latency", dlog_cyc[0] - t0, 7);
            chk("t1_result", dlog_res[0], 'h104);
        end
        wait_quiet();

        // Pointer now 3; requesters 0, 1, 3 held.
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) rl[i] = LEN_W'(1);
        rq = 4'b1011;
        wait_grants(3);
        rq = '0;
        if (glog.size() >= 3) begin
            chk("t3_order0", glog[0], 3);
            chk("t3_order1", glog[1], 0);
            chk("t3_order2", glog[2], 1);
        end
        wait_quiet();

        // Zero length behaves as one.
        clear_logs();
        rd[1] = 10'h055;
        rl[1] = 6'd0;
        t0 = cyc;
        rq = 4'b0010;
        wait_grants(1);
        rq = '0;
        wait_dones(1);
        if (dlog_cyc.size() >= 1) begin
            chk("t4_latency", dlog_cyc[0] - t0, 3);
            chk("t4_result", dlog_res[0], 'h055);
        end
        wait_quiet();

        // Counter wrap passes straight through.
        clear_logs();
        rd[0] = 10'h3FE;
        rl[0] = 6'd4;
        t0 = cyc;
        rq = 4'b0001;
        wait_grants(1);
        rq = '0;
        wait_dones(1);
        if (dlog_cyc.size() >= 1) begin
            chk("t5_latency", dlog_cyc[0] - t0, 6);
            chk("t5_result", dlog_res[0], 'h001);
        end
        wait_quiet();

        // Random traffic: hold until grant, occasional withdrawal, re-request after grant.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i]) begin
                    if (grant[i]) begin
                        if ($urandom_range(0, 1) == 0) begin
                            rq[i] = 1'b0;
                        end else begin
                            rd[i] = DATA_W'($urandom);
                            rl[i] = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 7));
                        end
                    end else if ($urandom_range(0, 31) == 0) begin
                        rq[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                    rd[i] = DATA_W'($urandom);
                    rl[i] = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 7));
                end
            end
            step();
        end
        rq = '0;
        wait_quiet();

        // Reset in the middle of a long job aborts it silently.
        clear_logs();
        rd[3] = 10'h2A0;
        rl[3] = 6'd20;
        rq = 4'b1000;
        wait_grants(1);
        rq = '0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check_all_zero("abort");
        reset = 1'b0;
        clear_logs();
        rl[0] = 6'd1;
        rl[3] = 6'd1;
        rq = 4'b1001;
        wait_grants(1);
        rq = '0;
        if (glog.size() >= 1) chk("t6_first_grant", glog[0], 0);
        wait_quiet();
        repeat (30) step();
        chk("t6_no_stray_done", dlog_cyc.size(), 1);

        chk("queues_empty", gq.size() + dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
